// File: rtl/test_seq_pkg.sv
// Shared types for the test sequencer: FSM state encoding, the verdict
// encoding driven onto the {status_pass, status_fail} reporter lines, and a
// width helper for the small internal counters.
package test_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPORT = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    // Bit 1 drives status_pass, bit 0 drives status_fail.
    typedef enum logic [1:0] {
        VERDICT_NONE     = 2'b00,
        VERDICT_FAIL     = 2'b01,
        VERDICT_PASS     = 2'b10,
        VERDICT_FINISHED = 2'b11
    } verdict_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/test_sequencer_if.sv
// Handshake/status bundle between the test sequencer, the DUT under test and
// the test-status reporter. The master side is the sequencer itself.
interface test_sequencer_if #(
    parameter int unsigned ID_W = 2
);

    logic            start;
    logic            dut_done;
    logic            dut_error;
    logic [ID_W-1:0] test_id;
    logic            test_rst;
    logic            test_start;
    logic            status_pass;
    logic            status_fail;
    logic            timeout_flag;
    logic [ID_W:0]   pass_count;
    logic [ID_W:0]   fail_count;
    logic            busy;
    logic            done;

    modport master (
        input  start, dut_done, dut_error,
        output test_id, test_rst, test_start, status_pass, status_fail,
               timeout_flag, pass_count, fail_count, busy, done
    );

    modport slave (
        output start, dut_done, dut_error,
        input  test_id, test_rst, test_start, status_pass, status_fail,
               timeout_flag, pass_count, fail_count, busy, done
    );

endinterface

// File: rtl/test_sequencer_watchdog.sv
// Per-test watchdog: counts enabled cycles from zero after a clear and flags
// expiry when the count reaches TIMEOUT-1. The count saturates there so a
// lingering enable can never wrap it back to a non-expired value.
module test_watchdog
    import test_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned      CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]    LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise advance while enabled up to LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/test_sequencer.sv
// Test sequencer: runs NUM_TESTS tests one after another against a shared
// DUT. Each test gets a test-local reset, a start pulse, a watchdog-bounded
// run window and a held verdict on the reporter lines, followed by a one
// cycle gap so every verdict presents a fresh edge to the reporter.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int unsigned NUM_TESTS     = 4,
    parameter int unsigned TIMEOUT       = 100,
    parameter int unsigned RST_CYCLES    = 2,
    parameter int unsigned REPORT_CYCLES = 2,
    parameter int unsigned ID_W          = 2
) (
    input  logic             clk,
    input  logic             reset,
    test_sequencer_if.master bus
);

    localparam int unsigned     RW       = cnt_width(RST_CYCLES);
    localparam int unsigned     PW       = cnt_width(REPORT_CYCLES);
    localparam logic [RW-1:0]   RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [PW-1:0]   REP_LAST = PW'(REPORT_CYCLES - 1);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_TESTS - 1);

    state_e          state_q;
    verdict_e        verdict_q;
    logic [ID_W-1:0] test_id_q;
    logic [RW-1:0]   rst_cnt_q;
    logic [PW-1:0]   rep_cnt_q;
    logic            err_q;
    logic            tflag_q;
    logic [ID_W:0]   pass_cnt_q;
    logic [ID_W:0]   fail_cnt_q;
    logic            test_rst_q;
    logic            test_start_q;
    logic            busy_q;
    logic            done_q;

    logic            wd_clr;
    logic            wd_en;
    logic            wd_expired;

    assign wd_clr = (state_q == ST_RESET);
    assign wd_en  = (state_q == ST_RUN);

    test_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // Sequencing FSM with error latch, verdict counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            verdict_q    <= VERDICT_NONE;
            test_id_q    <= '0;
            rst_cnt_q    <= '0;
            rep_cnt_q    <= '0;
            err_q        <= 1'b0;
            tflag_q      <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            test_rst_q   <= 1'b0;
            test_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            test_start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FINISH: begin
                    if (bus.start) begin
                        state_q    <= ST_RESET;
                        verdict_q  <= VERDICT_NONE;
                        test_id_q  <= '0;
                        rst_cnt_q  <= '0;
                        tflag_q    <= 1'b0;
                        pass_cnt_q <= '0;
                        fail_cnt_q <= '0;
                        test_rst_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                ST_RESET: begin
                    err_q <= 1'b0;
                    if (rst_cnt_q == RST_LAST) begin
                        state_q      <= ST_RUN;
                        test_rst_q   <= 1'b0;
                        test_start_q <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    err_q <= err_q | bus.dut_error;
                    // dut_done takes priority over a coincident watchdog expiry.
                    if (bus.dut_done) begin
                        state_q   <= ST_REPORT;
                        rep_cnt_q <= '0;
                        tflag_q   <= 1'b0;
                        if (err_q || bus.dut_error) begin
                            verdict_q  <= VERDICT_FAIL;
                            fail_cnt_q <= fail_cnt_q + 1'b1;
                        end else begin
                            verdict_q  <= VERDICT_PASS;
                            pass_cnt_q <= pass_cnt_q + 1'b1;
                        end
                    end else if (wd_expired) begin
                        state_q    <= ST_REPORT;
                        rep_cnt_q  <= '0;
                        tflag_q    <= 1'b1;
                        verdict_q  <= VERDICT_FAIL;
                        fail_cnt_q <= fail_cnt_q + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (rep_cnt_q == REP_LAST) begin
                        state_q   <= ST_GAP;
                        verdict_q <= VERDICT_NONE;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (test_id_q == LAST_ID) begin
                        state_q   <= ST_FINISH;
                        verdict_q <= VERDICT_FINISHED;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        state_q    <= ST_RESET;
                        test_id_q  <= test_id_q + 1'b1;
                        rst_cnt_q  <= '0;
                        test_rst_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.test_id      = test_id_q;
    assign bus.test_rst     = test_rst_q;
    assign bus.test_start   = test_start_q;
    assign bus.status_pass  = verdict_q[1];
    assign bus.status_fail  = verdict_q[0];
    assign bus.timeout_flag = tflag_q;
    assign bus.pass_count   = pass_cnt_q;
    assign bus.fail_count   = fail_cnt_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule
